ysyx_23060332_ifu: RTL and testbench
====================================

# ysyx_23060332_ifu

Instruction fetch unit: owns the PC, fetches one 32-bit instruction at a time over a req/ack instruction-memory port, and presents it with its address to the decode stage under a valid/ready handshake. It is the producer end of the decode stage's `inst_i` and `inst_addr` inputs. It takes the next-PC redirect (jal/jalr/branch) from the execute stage in the cycle the instruction is consumed.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset and first fetch address
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request; held high until accepted
- imem_addr  out  `InstAddrBus`  fetch address; stable while imem_req high
- imem_ack  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  `InstBus`  instruction word, valid when imem_req && imem_ack
- inst_o  out  `InstBus`  instruction to decode
- inst_addr_o  out  `InstAddrBus`  PC of inst_o
- inst_valid  out  1  inst_o/inst_addr_o hold a fetched instruction
- inst_ready  in  1  decode/execute consumes inst_o this cycle
- jump_en  in  1  redirect; qualified only by inst_valid && inst_ready
- jump_addr  in  `InstAddrBus`  redirect target

## Operation
- States: IDLE, REQ, VALID, HALT (HALT exists only with the macro enabled).
- IDLE: entered on reset; next cycle -> REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: inst_o<=imem_rdata, inst_addr_o<=pc, -> VALID. No ack: stay; pc and imem_addr unchanged.
- VALID: inst_valid=1, imem_req=0. On inst_ready: pc<=jump_en ? jump_addr : pc+4 (32-bit wrap, carry dropped), -> REQ. No ready: hold inst_o/inst_addr_o unchanged.
- Fetch transfer = imem_req && imem_ack; ack while imem_req=0 is ignored.
- jump_en/jump_addr are ignored unless inst_valid && inst_ready in the same cycle.
- pc+4 at 32'hFFFF_FFFC wraps to 32'h0000_0000.
- rst while in any state: next cycle IDLE; an in-flight request is abandoned and its late ack is ignored. The memory side must tolerate a dropped request.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_o=`INST_NOP` (32'h0000_0013), inst_addr_o=RESET_PC, pc=RESET_PC, state IDLE.
- inst_o resets to NOP, not zero, so that decode does not trap on an unknown opcode.
- First request: imem_req high in the first cycle after rst falls.
- Ack in cycle N -> inst_valid high in N+1.
- Ready in cycle M -> imem_req high in M+1 with the new address.
- Best case is 2 cycles per instruction (zero-wait memory, ready always high).
- Outputs are registered; there is no combinational path from imem_ack or inst_ready to any output.

## Configuration
- YSYX_23060332_IFU_MISALIGN_EN defined:
  - A redirect with jump_addr[1:0]!=0 at handshake calls DPI `npc_trap()` once and enters HALT.
  - HALT: imem_req=0, inst_valid=0; exited only by rst.
- Undefined:
  - jump_addr[1:0] is masked to 2'b00 and fetch continues.
  - No HALT state and no DPI import.

## Structure
- Shared header ysyx_23060332_define.v holds `InstBus`, `InstAddrBus`, `ZeroWord`, and the new `INST_NOP`.
- FSM state encodings are local to the module.
- Sub-module ysyx_23060332_pc_reg contains the PC register with the reset value and the next-PC mux (seq/redirect/mask).

## Test plan
- Reset release, memory acks immediately with 32'h0000_0093 -> cycle 1 imem_addr=8000_0000; cycle 2 inst_valid=1, inst_o=0000_0093, inst_addr_o=8000_0000.
- Ready always high, zero-wait memory, 3 fetches -> addresses 8000_0000, 8000_0004, 8000_0008 on alternate cycles.
- Ack delayed 5 cycles -> imem_req and imem_addr held stable for all 5 cycles; exactly one instruction is delivered.
- Handshake with jump_en=1, jump_addr=8000_0100 -> next imem_addr=8000_0100.
- jump_en=1 while inst_ready=0 -> ignored; a later plain handshake fetches pc+4.
- rst mid-REQ, then a stray ack -> IDLE, then REQ at 8000_0000; the stray data is not captured.
- jump_addr=8000_0102 at handshake:
  - Macro on -> npc_trap called, HALT, no further imem_req.
  - Macro off -> next imem_addr=8000_0100.

Source files
------------

// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared constants and next-PC helpers for the ysyx_23060332 instruction fetch unit.
// Optional misaligned-redirect trap is enabled with YSYX_23060332_IFU_MISALIGN_EN.
package ysyx_23060332_ifu_pkg;

    localparam int          INST_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Sequential PC; the carry out of bit 31 is dropped so 32'hFFFF_FFFC wraps to zero.
    function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// Fetch-unit bus: instruction-memory req/ack port plus the decode valid/ready port.
// master = fetch unit, slave = memory/decode environment.
interface ysyx_23060332_ifu_if
    import ysyx_23060332_ifu_pkg::*;
();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_valid;
    logic              inst_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;

    modport master (
        output imem_req, imem_addr, inst_o, inst_addr_o, inst_valid,
        input  imem_ack, imem_rdata, inst_ready, jump_en, jump_addr
    );

    modport slave (
        input  imem_req, imem_addr, inst_o, inst_addr_o, inst_valid,
        output imem_ack, imem_rdata, inst_ready, jump_en, jump_addr
    );
endinterface

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter register with its next-PC mux (hold / sequential / aligned redirect).
// Built identically with or without YSYX_23060332_IFU_MISALIGN_EN.
module ysyx_23060332_pc_reg
    import ysyx_23060332_ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    input  logic              i_jump_en,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Next PC only moves when decode consumes the current instruction.
    always_comb begin
        w_pc_next = r_pc;
        if (i_adv) begin
            if (i_jump_en) begin
                w_pc_next = align_word(i_jump_addr);
            end else begin
                w_pc_next = seq_pc(r_pc);
            end
        end else begin
            w_pc_next = r_pc;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding fetch, registered handoff to decode.
// Define YSYX_23060332_IFU_MISALIGN_EN to trap and halt on misaligned redirects.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ysyx_23060332_ifu_if.master  bus
);

`ifdef YSYX_23060332_IFU_MISALIGN_EN
    function automatic void npc_trap();
        $display("npc_trap: misaligned redirect");
    endfunction
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_VALID = 2'd2, S_HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_VALID = 2'd2} state_t;
`endif

    state_t            r_state;
    logic              r_imem_req;
    logic [ADDR_W-1:0] r_imem_addr;
    logic              r_inst_valid;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_addr;

    logic              w_fire;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_fire = (r_state == S_VALID) && bus.inst_ready;

    ysyx_23060332_pc_reg u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (w_fire),
        .i_jump_en   (bus.jump_en),
        .i_jump_addr (bus.jump_addr),
        .o_pc        (w_pc),
        .o_pc_next   (w_pc_next)
    );

    // Fetch FSM; every bus output is a register so neither ack nor ready reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= INST_NOP;
            r_inst_addr  <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_REQ;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_pc;
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        r_state      <= S_VALID;
                        r_imem_req   <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_inst       <= bus.imem_rdata;
                        r_inst_addr  <= w_pc;
                    end
                end
                S_VALID: begin
                    if (bus.inst_ready) begin
`ifdef YSYX_23060332_IFU_MISALIGN_EN
                        if (bus.jump_en && (bus.jump_addr[1:0] != 2'b00)) begin
                            npc_trap();
                            r_state      <= S_HALT;
                            r_imem_req   <= 1'b0;
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_state      <= S_REQ;
                            r_imem_req   <= 1'b1;
                            r_imem_addr  <= w_pc_next;
                            r_inst_valid <= 1'b0;
                        end
`else
                        r_state      <= S_REQ;
                        r_imem_req   <= 1'b1;
                        r_imem_addr  <= w_pc_next;
                        r_inst_valid <= 1'b0;
`endif
                    end
                end
`ifdef YSYX_23060332_IFU_MISALIGN_EN
                S_HALT: begin
                    r_imem_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
`endif
                default: begin
                    r_state      <= S_IDLE;
                    r_imem_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_imem_addr;
    assign bus.inst_valid  = r_inst_valid;
    assign bus.inst_o      = r_inst;
    assign bus.inst_addr_o = r_inst_addr;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed scoreboard bench for ysyx_23060332_ifu: acked fetches are queued with their
// expected PC and compared when decode consumes them.
module tb_ysyx_23060332_ifu;
    import ysyx_23060332_ifu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060332_ifu_if bus_if ();

    ysyx_23060332_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          t0;
    logic [31:0] exp_pc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        bus_if.inst_ready = 1'b0;
        bus_if.jump_en    = 1'b0;
        bus_if.jump_addr  = 32'h0;
        step();
        step();
        chk("rst_req",       {31'd0, bus_if.imem_req},   32'd0);
        chk("rst_addr",      bus_if.imem_addr,           RESET_PC);
        chk("rst_valid",     {31'd0, bus_if.inst_valid}, 32'd0);
        chk("rst_inst",      bus_if.inst_o,              INST_NOP);
        chk("rst_inst_addr", bus_if.inst_addr_o,         RESET_PC);
        rst = 1'b0;
        step();
        exp_pc = RESET_PC;
        sb.delete();
    endtask

    // Expects REQ at entry; acks after wait_n idle request cycles.
    task automatic fetch(input logic [31:0] data, input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            chk("req_wait",  {31'd0, bus_if.imem_req}, 32'd1);
            chk("addr_wait", bus_if.imem_addr,         exp_pc);
            step();
        end
        chk("req",          {31'd0, bus_if.imem_req},   32'd1);
        chk("addr",         bus_if.imem_addr,           exp_pc);
        chk("valid_in_req", {31'd0, bus_if.inst_valid}, 32'd0);
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = data;
        sb.push_back({exp_pc, data});
        step();
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = $urandom;
    endtask

    // Holds ready low for wait_n cycles (with stray jump/ack noise), then consumes.
    task automatic consume(input logic je, input logic [31:0] ja, input int wait_n);
        exp_t e;
        e = sb.pop_front();
        for (int i = 0; i < wait_n; i++) begin
            chk("hold_valid", {31'd0, bus_if.inst_valid}, 32'd1);
            chk("hold_inst",  bus_if.inst_o,              e.data);
            chk("hold_iaddr", bus_if.inst_addr_o,         e.addr);
            chk("hold_noreq", {31'd0, bus_if.imem_req},   32'd0);
            bus_if.jump_en    = 1'b1;
            bus_if.jump_addr  = $urandom;
            bus_if.imem_ack   = 1'b1;
            bus_if.imem_rdata = $urandom;
            step();
            bus_if.jump_en  = 1'b0;
            bus_if.imem_ack = 1'b0;
        end
        chk("valid",     {31'd0, bus_if.inst_valid}, 32'd1);
        chk("inst",      bus_if.inst_o,              e.data);
        chk("inst_addr", bus_if.inst_addr_o,         e.addr);
        chk("noreq",     {31'd0, bus_if.imem_req},   32'd0);
        bus_if.inst_ready = 1'b1;
        bus_if.jump_en    = je;
        bus_if.jump_addr  = ja;
        step();
        bus_if.inst_ready = 1'b0;
        bus_if.jump_en    = 1'b0;
        exp_pc = je ? (ja & 32'hFFFF_FFFC) : (exp_pc + 32'd4);
        chk("valid_drop", {31'd0, bus_if.inst_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // First fetch straight out of reset.
        do_reset();
        fetch(32'h0000_0093, 0);
        consume(1'b0, 32'h0, 0);

        // Zero-wait memory, ready immediately: one request every two cycles.
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            chk("spacing", 32'(cyc - t0), 32'(2 * i));
            fetch($urandom, 0);
            consume(1'b0, 32'h0, 0);
        end

        // Slow memory: request held for five cycles, one instruction delivered.
        fetch(32'h1234_5678, 5);
        consume(1'b0, 32'h0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Redirect at handshake, then a redirect offered while not ready.
        fetch($urandom, 0);
        consume(1'b1, 32'h8000_0100, 0);
        fetch($urandom, 0);
        consume(1'b0, 32'h0, 3);

        // Wrap past the top of the address space.
        fetch($urandom, 1);
        consume(1'b1, 32'hFFFF_FFFC, 0);
        fetch($urandom, 0);
        consume(1'b0, 32'h0, 0);
        chk("wrap_pc", bus_if.imem_addr, 32'h0000_0000);
        fetch($urandom, 0);
        consume(1'b0, 32'h0, 0);

        // Reset while requesting, followed by a stray ack.
        chk("pre_rst_req", {31'd0, bus_if.imem_req}, 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_req", {31'd0, bus_if.imem_req}, 32'd0);
        rst = 1'b0;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus_if.imem_ack = 1'b0;
        exp_pc = RESET_PC;
        sb.delete();
        chk("stray_req",   {31'd0, bus_if.imem_req},   32'd1);
        chk("stray_addr",  bus_if.imem_addr,           RESET_PC);
        chk("stray_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        chk("stray_inst",  bus_if.inst_o,              INST_NOP);
        step();
        chk("stray_valid2", {31'd0, bus_if.inst_valid}, 32'd0);

        // Misaligned redirect.
        fetch(32'h0000_0067, 0);
`ifdef YSYX_23060332_IFU_MISALIGN_EN
        void'(sb.pop_front());
        bus_if.inst_ready = 1'b1;
        bus_if.jump_en    = 1'b1;
        bus_if.jump_addr  = 32'h8000_0102;
        step();
        bus_if.inst_ready = 1'b0;
        bus_if.jump_en    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.imem_ack = 1'b1;
            chk("halt_req",   {31'd0, bus_if.imem_req},   32'd0);
            chk("halt_valid", {31'd0, bus_if.inst_valid}, 32'd0);
            step();
        end
        bus_if.imem_ack = 1'b0;
`else
        consume(1'b1, 32'h8000_0102, 0);
        chk("misalign_addr", bus_if.imem_addr, 32'h8000_0100);
        fetch($urandom, 0);
        consume(1'b0, 32'h0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
